// File: rtl/center_of_mass.sv
// Pressure-weighted centroid of one tactile frame, scaled to display pixels.
// Accumulates weighted cell sums, then two restoring dividers run in parallel, one quotient bit per cycle.

module com_div_axis (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [23:0] sum,
  input  logic [19:0] mass,
  output logic [9:0]  q_nxt
);
  logic [19:0] rem;
  logic [9:0]  lo;
  logic [9:0]  q;
  logic [20:0] trial;
  logic        ge;

  // (sum << 6) is split so that rem starts as dividend >> 10, which is below mass whenever Q < 1024
  assign trial = {rem, lo[9]};
  assign ge    = trial >= {1'b0, mass};
  assign q_nxt = {q[8:0], ge};

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem <= '0;
      lo  <= '0;
      q   <= '0;
    end else if (load) begin
      rem <= sum[23:4];
      lo  <= {sum[3:0], 6'b0};
      q   <= '0;
    end else if (step) begin
      rem <= ge ? 20'(trial - {1'b0, mass}) : trial[19:0];
      lo  <= {lo[8:0], 1'b0};
      q   <= q_nxt;
    end
  end
endmodule

module center_of_mass #(
  parameter int SW_WIRE_CNT = 16,
  parameter int RD_WIRE_CNT = 16,
  parameter int VAL_WIDTH   = 12,
  parameter int THRESHOLD   = 200,
  parameter int MIN_MASS    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_valid,
  input  logic [3:0]           sample_sw,
  input  logic [3:0]           sample_rd,
  input  logic [VAL_WIDTH-1:0] sample_val,
  input  logic                 frame_done,
  input  logic [1:0]           scale_in,
  output logic [10:0]          x_com,
  output logic [9:0]           y_com,
  output logic                 touch,
  output logic                 com_valid,
  output logic                 busy
);
  typedef enum logic [1:0] {ACCUM, DIV, OUT} state_t;

  state_t               state, state_nxt;
  logic [3:0]           cnt;
  logic [19:0]          mass, mass_nxt, mass_lat;
  logic [1:0][23:0]     sum, sum_nxt;
  logic [1:0][3:0]      idx;
  logic [1:0][9:0]      q_nxt;
  logic [VAL_WIDTH-1:0] w;
  logic [1:0]           scale_lat;
  logic                 take, start, step, last;

  function automatic logic [10:0] scale_px(input logic [9:0] q, input logic [1:0] s);
    logic [15:0] p;
    logic [10:0] half;
    case (s)
      2'd1:    begin p = {2'b0, q, 4'b0}; half = 11'd8;  end
      2'd2:    begin p = {1'b0, q, 5'b0}; half = 11'd16; end
      2'd3:    begin p = {q, 6'b0};       half = 11'd32; end
      default: begin p = {6'b0, q};       half = 11'd0;  end
    endcase
    return 11'(p >> 6) + half;
  endfunction

  assign take  = sample_valid && (state == ACCUM) &&
                 (32'(sample_sw) < SW_WIRE_CNT) && (32'(sample_rd) < RD_WIRE_CNT);
  assign w     = (sample_val > VAL_WIDTH'(THRESHOLD)) ? sample_val - VAL_WIDTH'(THRESHOLD) : '0;
  assign idx   = {sample_sw, sample_rd};   // axis 0 = x (read wire), axis 1 = y (switch wire)
  assign start = (state == ACCUM) && frame_done;
  assign step  = (state == DIV);
  assign last  = (state == DIV) && (cnt == 4'd9);

  always_comb begin
    mass_nxt = mass;
    sum_nxt  = sum;
    if (take) begin
      mass_nxt = mass + 20'(w);
      for (int a = 0; a < 2; a++) sum_nxt[a] = sum[a] + 24'(w) * 24'(idx[a]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || start) begin
      mass <= '0;
      sum  <= '0;
    end else begin
      mass <= mass_nxt;
      sum  <= sum_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mass_lat  <= '0;
      scale_lat <= '0;
    end else if (start) begin
      mass_lat  <= mass_nxt;
      scale_lat <= scale_in;
    end
  end

  for (genvar a = 0; a < 2; a++) begin : g_axis
    com_div_axis u_div (
      .clk   (clk),
      .rst   (rst),
      .load  (start),
      .step  (step),
      .sum   (sum_nxt[a]),
      .mass  (mass_lat),
      .q_nxt (q_nxt[a])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ACCUM;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == DIV) ? cnt + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (frame_done) state_nxt = DIV;
      DIV:     if (cnt == 4'd9) state_nxt = OUT;
      OUT:     state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Results are registered on the final divide step so they appear together with com_valid in OUT
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_com     <= 11'h7FF;
      y_com     <= 10'h3FF;
      touch     <= 1'b0;
      com_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      com_valid <= last;
      busy      <= (state_nxt != ACCUM);
      if (last) begin
        if (mass_lat < 20'(MIN_MASS)) begin
          x_com <= 11'h7FF;
          y_com <= 10'h3FF;
          touch <= 1'b0;
        end else begin
          x_com <= scale_px(q_nxt[0], scale_lat);
          y_com <= 10'(scale_px(q_nxt[1], scale_lat));
          touch <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_center_of_mass.sv
// Table-driven frames with a result scoreboard, plus busy-drop and mid-divide reset sequences.

module tb_center_of_mass;
  logic        clk = 0, rst = 0, sample_valid = 0, frame_done = 0;
  logic [3:0]  sample_sw = 0, sample_rd = 0;
  logic [11:0] sample_val = 0;
  logic [1:0]  scale_in = 0;
  logic [10:0] x_com;
  logic [9:0]  y_com;
  logic        touch, com_valid, busy;

  typedef struct {
    int n;
    int s0, r0, v0, s1, r1, v1;
    int sc, ex, ey, et;
  } vec_t;

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
    logic        t;
    int          t0;
  } exp_t;

  vec_t        vt[12];
  exp_t        sb[$];
  exp_t        mon_e;
  logic [10:0] held_x = 11'h7FF;
  logic [9:0]  held_y = 10'h3FF;
  logic        held_t = 0;
  int          n_vec = 0, n_err = 0, cyc = 0, bad = 0;

  center_of_mass dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_sw(sample_sw),
    .sample_rd(sample_rd), .sample_val(sample_val), .frame_done(frame_done),
    .scale_in(scale_in), .x_com(x_com), .y_com(y_com), .touch(touch),
    .com_valid(com_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic vec_t mk(int n, int s0, int r0, int v0, int s1, int r1, int v1,
                              int sc, int ex, int ey, int et);
    vec_t v;
    v.n = n; v.s0 = s0; v.r0 = r0; v.v0 = v0; v.s1 = s1; v.r1 = r1; v.v1 = v1;
    v.sc = sc; v.ex = ex; v.ey = ey; v.et = et;
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst && com_valid) begin
      if (sb.size() == 0) chk("unexpected com_valid", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("x_com", int'(x_com), int'(mon_e.x));
        chk("y_com", int'(y_com), int'(mon_e.y));
        chk("touch", int'(touch), int'(mon_e.t));
        chk("latency", cyc + 1 - mon_e.t0, 11);
        held_x = mon_e.x; held_y = mon_e.y; held_t = mon_e.t;
      end
    end
  end

  // last cell always shares its cycle with frame_done; scale_in is disturbed afterwards
  task automatic send(input vec_t v, input bit push);
    for (int i = 0; i < v.n; i++) begin
      sample_valid = 1;
      sample_sw    = 4'(i == 0 ? v.s0 : v.s1);
      sample_rd    = 4'(i == 0 ? v.r0 : v.r1);
      sample_val   = 12'(i == 0 ? v.v0 : v.v1);
      frame_done   = (i == v.n - 1);
      scale_in     = 2'(v.sc);
      @(posedge clk); #1;
    end
    sample_valid = 0;
    frame_done   = 0;
    scale_in     = ~scale_in;
    if (push) sb.push_back('{x: 11'(v.ex), y: 10'(v.ey), t: v.et[0], t0: cyc});
  endtask

  task automatic wait_done();
    int k = 0;
    while (sb.size() > 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (sb.size() > 0) begin
      chk("result timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    chk("held x_com", int'(x_com), int'(held_x));
    chk("held y_com", int'(y_com), int'(held_y));
    chk("held touch", int'(touch), int'(held_t));
  endtask

  initial begin
    vt[0]  = mk(1,  3,  5, 1200, 0, 0,   0, 1,   88,   56, 1);
    vt[1]  = mk(2,  2,  4,  700, 2, 6, 700, 0,    5,    2, 1);
    vt[2]  = mk(2,  1,  0,  300, 1, 3, 400, 2,   80,   48, 1);
    vt[3]  = mk(2,  5,  5,  200, 6, 6, 150, 1, 'h7FF, 'h3FF, 0);
    vt[4]  = mk(1,  4,  4,  250, 0, 0,   0, 1, 'h7FF, 'h3FF, 0);
    vt[5]  = mk(1, 15, 15, 4095, 0, 0,   0, 3,  992,  992, 1);
    vt[6]  = mk(2,  0,  0,  264, 0, 0, 264, 0,    0,    0, 1);
    vt[7]  = mk(1,  0,  0,  264, 0, 0,   0, 0,    0,    0, 1);
    vt[8]  = mk(1,  0,  0,  263, 0, 0,   0, 0, 'h7FF, 'h3FF, 0);
    vt[9]  = mk(2,  0,  0,  300, 0, 1, 400, 1,   18,    8, 1);
    vt[10] = mk(2,  0,  0,  300, 0, 1, 400, 2,   37,   16, 1);
    vt[11] = mk(2,  7,  9, 1000, 7, 9, 1000, 0,   9,    7, 1);

    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset x_com", int'(x_com), 'h7FF);
    chk("reset y_com", int'(y_com), 'h3FF);
    chk("reset touch", int'(touch), 0);
    chk("reset com_valid", int'(com_valid), 0);
    chk("reset busy", int'(busy), 0);
    rst = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      send(vt[i], 1);
      wait_done();
    end

    // samples and a second frame_done during busy must vanish
    send(vt[0], 1);
    bad = 0;
    for (int k = 0; k < 11; k++) begin
      if (!busy) bad++;
      sample_valid = 1; sample_sw = 0; sample_rd = 0; sample_val = 12'hFFF;
      frame_done = (k == 4);
      @(posedge clk); #1;
    end
    sample_valid = 0;
    frame_done   = 0;
    chk("busy window", bad, 0);
    chk("busy falls", int'(busy), 0);
    wait_done();
    send(vt[1], 1);
    wait_done();

    // reset at T+5 aborts the divide
    send(vt[0], 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk); #1;
    chk("abort x_com", int'(x_com), 'h7FF);
    chk("abort y_com", int'(y_com), 'h3FF);
    chk("abort touch", int'(touch), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort com_valid", int'(com_valid), 0);
    @(posedge clk); #1;
    rst = 1;
    repeat (15) @(posedge clk);
    #1;
    chk("post-abort x_com", int'(x_com), 'h7FF);
    held_x = 11'h7FF; held_y = 10'h3FF; held_t = 0;
    send(vt[2], 1);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
